// File: rtl/instr_loader_if.sv
// ---------------------------------------------------------------------------
// instr_loader_if
// Bundles the byte stream coming from the UART receiver with the
// instruction-memory write port that the loader drives.
//   rx_data    [7:0]        received byte, valid when rx_valid is high
//   rx_valid                one-cycle strobe per received byte
//   imem_we                 instruction-memory write enable (one-cycle pulse)
//   imem_addr  [ADDR_W-1:0] write address
//   imem_wdata [15:0]       write data
// Modports: master = UART/memory side (drives rx, observes writes),
//           slave  = loader side (observes rx, drives writes).
// ---------------------------------------------------------------------------
interface instr_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;

  modport master (
    output rx_data,
    output rx_valid,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/instr_loader.sv
// ---------------------------------------------------------------------------
// instr_loader
// Loads a CPU program received over UART into instruction memory.
// Frame: 0xA5, count N, N big-endian 16-bit words (hi, lo), XOR sum byte.
// Words with an opcode the CPU cannot decode (0xB-0xE) are replaced by
// NONE (0xF000); words addressed past the end of memory are dropped.
// The CPU is held in stall while a load is in progress.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start             one-cycle pulse that (re)starts a load from any state
//   bus               instr_loader_if.slave: rx byte stream in, imem writes out
//   cpu_hold          high while a load is in progress
//   load_done         high after a completed frame until the next start
//   word_count        words written in the current or last load
//   err_opcode        sticky: illegal opcode replaced by NONE
//   err_checksum      sticky: sum byte did not match running XOR
//   err_overflow      sticky: word dropped, address beyond memory
//   err_timeout       sticky: frame aborted because the sender went silent
// ---------------------------------------------------------------------------
module instr_loader #(
  parameter int          ADDR_W  = 8,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  instr_loader_if.slave     bus,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_opcode,
  output logic              err_checksum,
  output logic              err_overflow,
  output logic              err_timeout
);

  localparam logic [7:0]  HDR_BYTE  = 8'hA5;
  localparam logic [15:0] NONE_WORD = 16'hF000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_CNT  = 3'd2,
    S_HI   = 3'd3,
    S_LO   = 3'd4,
    S_SUM  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  // Opcodes the CPU decoder accepts: 0x0-0xA and 0xF.
  function automatic logic opcode_legal(input logic [3:0] op);
    return (op <= 4'hA) || (op == 4'hF);
  endfunction

  // Replace a word whose opcode is not decodable by NONE.
  function automatic logic [15:0] sanitize_word(input logic [15:0] w);
    if (opcode_legal(w[15:12])) begin
      return w;
    end else begin
      return NONE_WORD;
    end
  endfunction

  state_t            state_r;
  logic [7:0]        hi_r;
  logic [7:0]        remain_r;
  logic [7:0]        xor_r;
  logic [15:0]       tmo_cnt_r;
  // word_count_r doubles as the next write address; its top bit set means
  // the address has run past the last memory location.
  logic [ADDR_W:0]   word_count_r;
  logic              imem_we_r;
  logic [ADDR_W-1:0] imem_addr_r;
  logic [15:0]       imem_wdata_r;
  logic              cpu_hold_r;
  logic              load_done_r;
  logic              err_opcode_r;
  logic              err_checksum_r;
  logic              err_overflow_r;
  logic              err_timeout_r;

  logic [15:0]       lo_word_s;
  logic              timed_s;

  assign lo_word_s = {hi_r, bus.rx_data};
  assign timed_s   = (state_r == S_CNT) || (state_r == S_HI) ||
                     (state_r == S_LO)  || (state_r == S_SUM);

  // Frame-parsing FSM with registered write port, status and error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= S_IDLE;
      hi_r           <= 8'd0;
      remain_r       <= 8'd0;
      xor_r          <= 8'd0;
      tmo_cnt_r      <= 16'd0;
      word_count_r   <= '0;
      imem_we_r      <= 1'b0;
      imem_addr_r    <= '0;
      imem_wdata_r   <= 16'd0;
      cpu_hold_r     <= 1'b0;
      load_done_r    <= 1'b0;
      err_opcode_r   <= 1'b0;
      err_checksum_r <= 1'b0;
      err_overflow_r <= 1'b0;
      err_timeout_r  <= 1'b0;
    end else begin
      imem_we_r <= 1'b0;
      if (start) begin
        // start wins over a byte arriving in the same cycle
        state_r        <= S_HDR;
        xor_r          <= 8'd0;
        tmo_cnt_r      <= 16'd0;
        word_count_r   <= '0;
        imem_addr_r    <= '0;
        cpu_hold_r     <= 1'b1;
        load_done_r    <= 1'b0;
        err_opcode_r   <= 1'b0;
        err_checksum_r <= 1'b0;
        err_overflow_r <= 1'b0;
        err_timeout_r  <= 1'b0;
      end else if (bus.rx_valid) begin
        tmo_cnt_r <= 16'd0;
        case (state_r)
          S_IDLE: begin
            state_r <= S_IDLE;
          end
          S_HDR: begin
            if (bus.rx_data == HDR_BYTE) begin
              state_r <= S_CNT;
            end else begin
              state_r <= S_HDR;
            end
          end
          S_CNT: begin
            remain_r <= bus.rx_data;
            xor_r    <= xor_r ^ bus.rx_data;
            if (bus.rx_data == 8'd0) begin
              state_r <= S_SUM;
            end else begin
              state_r <= S_HI;
            end
          end
          S_HI: begin
            hi_r    <= bus.rx_data;
            xor_r   <= xor_r ^ bus.rx_data;
            state_r <= S_LO;
          end
          S_LO: begin
            xor_r    <= xor_r ^ bus.rx_data;
            remain_r <= remain_r - 8'd1;
            if (!opcode_legal(lo_word_s[15:12])) begin
              err_opcode_r <= 1'b1;
            end else begin
              err_opcode_r <= err_opcode_r;
            end
            if (!word_count_r[ADDR_W]) begin
              imem_we_r    <= 1'b1;
              imem_addr_r  <= word_count_r[ADDR_W-1:0];
              imem_wdata_r <= sanitize_word(lo_word_s);
              word_count_r <= word_count_r + (ADDR_W+1)'(1);
            end else begin
              err_overflow_r <= 1'b1;
            end
            if (remain_r == 8'd1) begin
              state_r <= S_SUM;
            end else begin
              state_r <= S_HI;
            end
          end
          S_SUM: begin
            if (bus.rx_data != xor_r) begin
              err_checksum_r <= 1'b1;
            end else begin
              err_checksum_r <= err_checksum_r;
            end
            state_r     <= S_DONE;
            cpu_hold_r  <= 1'b0;
            load_done_r <= 1'b1;
          end
          S_DONE: begin
            state_r <= S_DONE;
          end
          default: begin
            state_r <= S_IDLE;
          end
        endcase
      end else if (timed_s) begin
        // counter was cleared on the last accepted byte; expiry lands
        // exactly TIMEOUT edges later
        if (tmo_cnt_r == (TIMEOUT - 16'd1)) begin
          state_r       <= S_IDLE;
          tmo_cnt_r     <= 16'd0;
          err_timeout_r <= 1'b1;
          cpu_hold_r    <= 1'b0;
          load_done_r   <= 1'b0;
        end else begin
          tmo_cnt_r <= tmo_cnt_r + 16'd1;
        end
      end else begin
        tmo_cnt_r <= 16'd0;
      end
    end
  end

  assign bus.imem_we    = imem_we_r;
  assign bus.imem_addr  = imem_addr_r;
  assign bus.imem_wdata = imem_wdata_r;
  assign cpu_hold       = cpu_hold_r;
  assign load_done      = load_done_r;
  assign word_count     = word_count_r;
  assign err_opcode     = err_opcode_r;
  assign err_checksum   = err_checksum_r;
  assign err_overflow   = err_overflow_r;
  assign err_timeout    = err_timeout_r;

endmodule

// File: tb/tb_instr_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_loader
// Self-checking bench for instr_loader with a 4-word memory (ADDR_W=2) and
// a short timeout (20 cycles). Fixed frames come from a vector table, the
// restart/timeout corners are hand-written, and random frames are checked
// against a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_instr_loader;

  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          cpu_hold;
  logic          load_done;
  logic [AW:0]   word_count;
  logic          err_opcode;
  logic          err_checksum;
  logic          err_overflow;
  logic          err_timeout;

  instr_loader_if #(.ADDR_W(AW)) bus ();

  instr_loader #(.ADDR_W(AW), .TIMEOUT(16'd20)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .word_count   (word_count),
    .err_opcode   (err_opcode),
    .err_checksum (err_checksum),
    .err_overflow (err_overflow),
    .err_timeout  (err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  int wq_addr[$];
  int wq_data[$];
  int wq_cyc[$];

  // cycle stamp for write-spacing checks
  always @(posedge clk) cyc <= cyc + 1;

  // capture every memory write away from the active edge
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wq_addr.push_back(int'(bus.imem_addr));
      wq_data.push_back(int'(bus.imem_wdata));
      wq_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // drive one byte for one cycle; returns at the following negedge
  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},   32'(bus.imem_we), 32'd0);
    chk({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
    chk({tag, "_wdat"}, 32'(bus.imem_wdata), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_done"}, 32'(load_done), 32'd0);
    chk({tag, "_wc"},   32'(word_count), 32'd0);
    chk({tag, "_errs"}, {28'd0, err_opcode, err_checksum, err_overflow, err_timeout}, 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [127:0] bytes;   // first byte in [127:120]
    logic [4:0]   nbytes;
    logic [127:0] wdata;   // first word in [127:112]
    logic [3:0]   nw;
    logic [3:0]   wc;
    logic         done;
    logic         eop;
    logic         ecs;
    logic         eov;
  } vec_t;

  vec_t tbl [6];

  // ---------------- reference model ----------------
  logic [7:0] fb[$];
  int         fg[$];

  task automatic model_check(input int f);
    int h, n, last, ab, lo_idx;
    logic [15:0] w;
    logic [7:0] x;
    int ea[$];
    int ed[$];
    logic eop, ecs, eov, eto, done;
    string s;
    eop = 1'b0; ecs = 1'b0; eov = 1'b0; eto = 1'b0; done = 1'b0;
    h = 0;
    while (h < fb.size() && fb[h] != 8'hA5) h++;
    n    = int'(fb[h+1]);
    last = h + 2*n + 2;
    ab   = -1;
    for (int j = h + 1; j <= last; j++)
      if (ab < 0 && fg[j] >= TMO) ab = j;
    for (int k = 0; k < n; k++) begin
      lo_idx = h + 3 + 2*k;
      if (ab >= 0 && lo_idx >= ab) break;
      w = {fb[h+2+2*k], fb[lo_idx]};
      if (w[15:12] >= 4'hB && w[15:12] <= 4'hE) begin
        eop = 1'b1;
        w = 16'hF000;
      end
      if (k < DEPTH) begin
        ea.push_back(k);
        ed.push_back(int'(w));
      end else begin
        eov = 1'b1;
      end
    end
    if (ab < 0) begin
      x = 8'd0;
      for (int j = h + 1; j < last; j++) x = x ^ fb[j];
      ecs  = (x != fb[last]);
      done = 1'b1;
    end else begin
      eto = 1'b1;
    end
    s = $sformatf("rnd%0d", f);
    chk({s, "_nwr"}, 32'(wq_addr.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < wq_addr.size(); i++) begin
      chk({s, "_addr"}, 32'(wq_addr[i]), 32'(ea[i]));
      chk({s, "_data"}, 32'(wq_data[i]), 32'(ed[i]));
    end
    chk({s, "_wc"},   32'(word_count), 32'(ea.size()));
    chk({s, "_done"}, 32'(load_done), 32'(done));
    chk({s, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({s, "_errs"}, {28'd0, err_opcode, err_checksum, err_overflow, err_timeout},
        {28'd0, eop, ecs, eov, eto});
  endtask

  initial begin
    logic [7:0] b, x, n8;
    int nj, h, last, j;
    string s;

    tbl[0] = '{bytes: {40'hA5_01_01_05_05, 88'd0}, nbytes: 5'd5,
               wdata: {16'h0105, 112'd0}, nw: 4'd1, wc: 4'd1,
               done: 1'b1, eop: 1'b0, ecs: 1'b0, eov: 1'b0};
    tbl[1] = '{bytes: {56'hA5_02_26_34_B1_23_82, 72'd0}, nbytes: 5'd7,
               wdata: {32'h2634_F000, 96'd0}, nw: 4'd2, wc: 4'd2,
               done: 1'b1, eop: 1'b1, ecs: 1'b0, eov: 1'b0};
    tbl[2] = '{bytes: {56'h00_FF_A5_01_01_05_00, 72'd0}, nbytes: 5'd7,
               wdata: {16'h0105, 112'd0}, nw: 4'd1, wc: 4'd1,
               done: 1'b1, eop: 1'b0, ecs: 1'b1, eov: 1'b0};
    tbl[3] = '{bytes: {104'hA5_05_10_01_20_02_30_03_40_04_50_05_14, 24'd0}, nbytes: 5'd13,
               wdata: {64'h1001_2002_3003_4004, 64'd0}, nw: 4'd4, wc: 4'd4,
               done: 1'b1, eop: 1'b0, ecs: 1'b0, eov: 1'b1};
    tbl[4] = '{bytes: {24'hA5_00_00, 104'd0}, nbytes: 5'd3,
               wdata: 128'd0, nw: 4'd0, wc: 4'd0,
               done: 1'b1, eop: 1'b0, ecs: 1'b0, eov: 1'b0};
    tbl[5] = '{bytes: {72'hA5_03_A0_00_F1_23_C0_00_B1, 56'd0}, nbytes: 5'd9,
               wdata: {48'hA000_F123_F000, 80'd0}, nw: 4'd3, wc: 4'd3,
               done: 1'b1, eop: 1'b1, ecs: 1'b0, eov: 1'b0};

    reset_n      = 1'b0;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    idle(3);
    chk_all_zero("reset");
    reset_n = 1'b1;
    idle(2);

    // ---- table-driven frames, bytes back-to-back ----
    for (int v = 0; v < 6; v++) begin
      s = $sformatf("vec%0d", v);
      do_start();
      chk({s, "_hold_on"}, 32'(cpu_hold), 32'd1);
      chk({s, "_st_wc"},   32'(word_count), 32'd0);
      for (int i = 0; i < int'(tbl[v].nbytes); i++)
        send(tbl[v].bytes[127 - 8*i -: 8]);
      chk({s, "_hold"}, 32'(cpu_hold), 32'd0);
      chk({s, "_done"}, 32'(load_done), 32'(tbl[v].done));
      idle(2);
      chk({s, "_nwr"}, 32'(wq_addr.size()), 32'(tbl[v].nw));
      for (int k = 0; k < int'(tbl[v].nw) && k < wq_addr.size(); k++) begin
        chk({s, "_addr"}, 32'(wq_addr[k]), 32'(k));
        chk({s, "_data"}, 32'(wq_data[k]), 32'(tbl[v].wdata[127 - 16*k -: 16]));
        if (k > 0) chk({s, "_wgap"}, 32'(wq_cyc[k] - wq_cyc[k-1]), 32'd2);
      end
      chk({s, "_wc"}, 32'(word_count), 32'(tbl[v].wc));
      chk({s, "_errs"}, {28'd0, err_opcode, err_checksum, err_overflow, err_timeout},
          {28'd0, tbl[v].eop, tbl[v].ecs, tbl[v].eov, 1'b0});
    end

    // ---- write pulse timing: one cycle after lo byte, one cycle only ----
    do_start();
    send(8'hA5); send(8'h01); send(8'h01); send(8'h05);
    chk("wr_we",   32'(bus.imem_we), 32'd1);
    chk("wr_addr", 32'(bus.imem_addr), 32'd0);
    chk("wr_data", 32'(bus.imem_wdata), 32'h0105);
    chk("wr_hold", 32'(cpu_hold), 32'd1);
    send(8'h05);
    chk("wr_we_off", 32'(bus.imem_we), 32'd0);
    chk("wr_done",   32'(load_done), 32'd1);
    chk("wr_hold2",  32'(cpu_hold), 32'd0);

    // ---- timeout exactly TMO cycles after the last byte ----
    do_start();
    send(8'hA5); send(8'h03); send(8'h12);
    idle(TMO - 1);
    chk("tmo_early_hold", 32'(cpu_hold), 32'd1);
    chk("tmo_early_flag", 32'(err_timeout), 32'd0);
    idle(1);
    chk("tmo_flag", 32'(err_timeout), 32'd1);
    chk("tmo_hold", 32'(cpu_hold), 32'd0);
    chk("tmo_done", 32'(load_done), 32'd0);
    send(8'hA5); send(8'h01); send(8'h01); send(8'h05); send(8'h05);
    idle(2);
    chk("tmo_idle_nwr",  32'(wq_addr.size()), 32'd0);
    chk("tmo_idle_done", 32'(load_done), 32'd0);

    // ---- asynchronous reset while in LO ----
    do_start();
    send(8'hA5); send(8'h02); send(8'hB1); send(8'h22); send(8'h33);
    chk("pre_rst_wc", 32'(word_count), 32'd1);
    chk("pre_rst_op", 32'(err_opcode), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_lo");
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);

    // ---- start together with rx_valid: that byte is discarded ----
    start        = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hA5;
    @(negedge clk);
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    send(8'h01); send(8'hA5); send(8'h00); send(8'h00);
    idle(2);
    chk("sv_done", 32'(load_done), 32'd1);
    chk("sv_wc",   32'(word_count), 32'd0);
    chk("sv_nwr",  32'(wq_addr.size()), 32'd0);
    chk("sv_cks",  32'(err_checksum), 32'd0);

    // ---- random frames against the reference model ----
    for (int f = 0; f < 40; f++) begin
      fb.delete(); fg.delete();
      nj = $urandom_range(0, 2);
      for (int i = 0; i < nj; i++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        fb.push_back(b);
        fg.push_back($urandom_range(0, 30));
      end
      h = fb.size();
      fb.push_back(8'hA5);
      fg.push_back($urandom_range(0, 3));
      n8 = 8'($urandom_range(0, 6));
      fb.push_back(n8);
      x = n8;
      for (int i = 0; i < 2 * int'(n8); i++) begin
        b = 8'($urandom_range(0, 255));
        fb.push_back(b);
        x = x ^ b;
      end
      if ($urandom_range(0, 3) == 0) fb.push_back(8'($urandom_range(0, 255)));
      else fb.push_back(x);
      last = fb.size() - 1;
      for (int i = h + 1; i <= last; i++) fg.push_back($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        j = $urandom_range(h + 1, last);
        fg[j] = $urandom_range(TMO, TMO + 5);
      end
      do_start();
      for (int i = 0; i < fb.size(); i++) begin
        idle(fg[i]);
        send(fb[i]);
      end
      idle(3);
      model_check(f);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
